// File: rtl/capture_seq_ctrl_if.sv
// Bundle of ADC stream, host control and buffer-write signals for capture_seq_ctrl.
// Latency: none (wires only).
// Backpressure: none; host_busy is the only stall input and it is consumed by the sequencer.
// Ports (DUT view, slave modport):
//   in : i_adc_data, i_adc_valid, i_arm, i_stop, i_force, i_cont, i_trig_level,
//        i_trig_slope, i_frame_len, i_host_busy
//   out: o_wr_data, o_wr_req, o_buf_sel, o_frame_done, o_frame_ready, o_overrun, o_state
// DATA_W / LEN_W must match the parameters of the capture_seq_ctrl instance.
interface capture_seq_ctrl_if #(
    parameter int DATA_W = 12,
    parameter int LEN_W  = 10
);
    logic [DATA_W-1:0] i_adc_data;
    logic              i_adc_valid;
    logic              i_arm;
    logic              i_stop;
    logic              i_force;
    logic              i_cont;
    logic [DATA_W-1:0] i_trig_level;
    logic              i_trig_slope;
    logic [LEN_W-1:0]  i_frame_len;
    logic              i_host_busy;
    logic [DATA_W-1:0] o_wr_data;
    logic              o_wr_req;
    logic              o_buf_sel;
    logic              o_frame_done;
    logic              o_frame_ready;
    logic              o_overrun;
    logic [1:0]        o_state;

    // Driver side: ADC front end plus host control.
    modport master (
        output i_adc_data, i_adc_valid, i_arm, i_stop, i_force, i_cont,
               i_trig_level, i_trig_slope, i_frame_len, i_host_busy,
        input  o_wr_data, o_wr_req, o_buf_sel, o_frame_done, o_frame_ready,
               o_overrun, o_state
    );

    // Sequencer side.
    modport slave (
        input  i_adc_data, i_adc_valid, i_arm, i_stop, i_force, i_cont,
               i_trig_level, i_trig_slope, i_frame_len, i_host_busy,
        output o_wr_data, o_wr_req, o_buf_sel, o_frame_done, o_frame_ready,
               o_overrun, o_state
    );
endinterface

// File: rtl/capture_seq_ctrl.sv
// Trigger/frame sequencer writing one frame per trigger into the ping/pang capture buffers.
// Latency: wr_req/wr_data registered, 1 cycle after the qualifying adc_valid; swap >= 1 cycle after DONE.
// Backpressure: none on the ADC stream; host_busy defers the buffer swap and samples are dropped meanwhile.
// Ports: clk, reset_n (async, active-low), bus (capture_seq_ctrl_if.slave, see interface file).
// Optional feature: define CAPTURE_AUTOTRIG_EN to auto-fire after AUTO_TMO cycles in ARMED.
module capture_seq_ctrl #(
    parameter int DATA_W   = 12,
    parameter int LEN_W    = 10,
    parameter int AUTO_TMO = 100000
) (
    input  logic              clk,
    input  logic              reset_n,
    capture_seq_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_ARMED   = 2'b01,
        ST_CAPTURE = 2'b10,
        ST_DONE    = 2'b11
    } state_t;

    state_t            r_state, w_state_nx;
    logic [DATA_W-1:0] r_prev, w_prev_nx;
    logic              r_prev_vld, w_prev_vld_nx;
    logic [LEN_W-1:0]  r_cnt, w_cnt_nx;
    logic [DATA_W-1:0] r_wr_data, w_wr_data_nx;
    logic              r_wr_req, w_wr_req_nx;
    logic              r_buf_sel, w_buf_sel_nx;
    logic              r_frame_done, w_frame_done_nx;
    logic              r_frame_ready, w_frame_ready_nx;
    logic              r_overrun, w_overrun_nx;
    logic              r_busy_d;
    logic [LEN_W-1:0]  w_last;
    logic              w_trig;
    logic              w_fire;
    logic              w_tmo_hit;
    logic              w_busy_rise;

    // Index of the last sample; a zero frame length still captures one sample.
    assign w_last      = (bus.i_frame_len == '0) ? '0 : bus.i_frame_len - 1'b1;
    assign w_busy_rise = bus.i_host_busy & ~r_busy_d;

    // Level crossing against the previous valid sample, unsigned full width.
    assign w_trig = bus.i_adc_valid && r_prev_vld &&
                    (bus.i_trig_slope ? ((r_prev > bus.i_trig_level) && (bus.i_adc_data <= bus.i_trig_level))
                                      : ((r_prev < bus.i_trig_level) && (bus.i_adc_data >= bus.i_trig_level)));

`ifdef CAPTURE_AUTOTRIG_EN
    localparam int TMO_W = (AUTO_TMO > 1) ? $clog2(AUTO_TMO) : 1;
    logic [TMO_W-1:0] r_tmo;

    // Counts consecutive ARMED cycles; restarts on every ARMED entry.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                                          r_tmo <= '0;
        else if (r_state == ST_ARMED && w_state_nx == ST_ARMED) r_tmo <= r_tmo + 1'b1;
        else                                                   r_tmo <= '0;
    end

    assign w_tmo_hit = (r_state == ST_ARMED) && (r_tmo == TMO_W'(AUTO_TMO - 1));
`else
    // Timeout disabled: ARMED waits indefinitely for a crossing or force.
    assign w_tmo_hit = 1'b0 & (AUTO_TMO == 0);
`endif

    assign w_fire = bus.i_force | w_tmo_hit;

    always_comb begin
        w_state_nx       = r_state;
        w_cnt_nx         = r_cnt;
        w_prev_nx        = r_prev;
        w_prev_vld_nx    = r_prev_vld;
        w_wr_req_nx      = 1'b0;
        w_wr_data_nx     = r_wr_data;
        w_buf_sel_nx     = r_buf_sel;
        w_frame_done_nx  = 1'b0;
        w_frame_ready_nx = r_frame_ready & ~w_busy_rise;
        w_overrun_nx     = bus.i_arm ? 1'b0 : r_overrun;

        if (bus.i_stop) begin
            // Abandon any partial frame; no swap, no frame_done.
            w_state_nx    = ST_IDLE;
            w_cnt_nx      = '0;
            w_prev_vld_nx = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_cnt_nx      = '0;
                    w_prev_vld_nx = 1'b0;
                    if (bus.i_arm) w_state_nx = ST_ARMED;
                end
                ST_ARMED: begin
                    if (bus.i_adc_valid) begin
                        w_prev_nx     = bus.i_adc_data;
                        w_prev_vld_nx = 1'b1;
                    end
                    if (w_trig) begin
                        // Triggering sample is sample 0 of the frame.
                        w_wr_req_nx  = 1'b1;
                        w_wr_data_nx = bus.i_adc_data;
                        if (w_last == '0) begin
                            w_state_nx = ST_DONE;
                            w_cnt_nx   = '0;
                        end else begin
                            w_state_nx = ST_CAPTURE;
                            w_cnt_nx   = LEN_W'(1);
                        end
                    end else if (w_fire) begin
                        // Forced start: the next valid sample becomes sample 0.
                        w_state_nx = ST_CAPTURE;
                        w_cnt_nx   = '0;
                    end
                end
                ST_CAPTURE: begin
                    if (bus.i_adc_valid) begin
                        w_wr_req_nx  = 1'b1;
                        w_wr_data_nx = bus.i_adc_data;
                        if (r_cnt >= w_last) begin
                            w_state_nx = ST_DONE;
                            w_cnt_nx   = '0;
                        end else begin
                            w_cnt_nx = r_cnt + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    // arm in the same cycle clears overrun and wins over a new drop.
                    if (bus.i_adc_valid && bus.i_cont && !bus.i_arm) w_overrun_nx = 1'b1;
                    if (!bus.i_host_busy) begin
                        w_buf_sel_nx     = ~r_buf_sel;
                        w_frame_done_nx  = 1'b1;
                        w_frame_ready_nx = 1'b1;
                        w_prev_vld_nx    = 1'b0;
                        w_state_nx       = bus.i_cont ? ST_ARMED : ST_IDLE;
                    end
                end
                default: w_state_nx = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_prev        <= '0;
            r_prev_vld    <= 1'b0;
            r_wr_req      <= 1'b0;
            r_wr_data     <= '0;
            r_buf_sel     <= 1'b0;
            r_frame_done  <= 1'b0;
            r_frame_ready <= 1'b0;
            r_overrun     <= 1'b0;
            r_busy_d      <= 1'b0;
        end else begin
            r_state       <= w_state_nx;
            r_cnt         <= w_cnt_nx;
            r_prev        <= w_prev_nx;
            r_prev_vld    <= w_prev_vld_nx;
            r_wr_req      <= w_wr_req_nx;
            r_wr_data     <= w_wr_data_nx;
            r_buf_sel     <= w_buf_sel_nx;
            r_frame_done  <= w_frame_done_nx;
            r_frame_ready <= w_frame_ready_nx;
            r_overrun     <= w_overrun_nx;
            r_busy_d      <= bus.i_host_busy;
        end
    end

    assign bus.o_state       = r_state;
    assign bus.o_wr_data     = r_wr_data;
    assign bus.o_wr_req      = r_wr_req;
    assign bus.o_buf_sel     = r_buf_sel;
    assign bus.o_frame_done  = r_frame_done;
    assign bus.o_frame_ready = r_frame_ready;
    assign bus.o_overrun     = r_overrun;
endmodule

// File: tb/tb_capture_seq_ctrl.sv
// Bench for capture_seq_ctrl: directed frames plus a randomized soak against a frame-level model.
// Latency: model predicts every output one edge ahead, compared #1 after the rising edge.
// Backpressure: host_busy is driven both directed and randomly.
module tb_capture_seq_ctrl;
    localparam int TMO = 16;
    localparam int S_IDLE = 0, S_ARMED = 1, S_CAP = 2, S_DONE = 3;

    logic clk;
    logic reset_n;

    capture_seq_ctrl_if #(.DATA_W(12), .LEN_W(10)) bus ();

    capture_seq_ctrl #(.DATA_W(12), .LEN_W(10), .AUTO_TMO(TMO)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: frame-level view (samples left in frame, history since arming).
    int md;
    int left;
    int armed_cyc;
    int hist[$];
    bit m_buf, m_ready, m_ovr, m_busy_prev;
    bit e_wr_req, e_done;
    int e_wr_data;

    // Observations of the current directed step.
    int n_wr_seen, n_done_seen, first_wr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit crossed(int p, int c, int lvl, bit falling);
        return falling ? (p > lvl && c <= lvl) : (p < lvl && c >= lvl);
    endfunction

    task automatic model_reset();
        md = S_IDLE; left = 0; armed_cyc = 0; hist.delete();
        m_buf = 0; m_ready = 0; m_ovr = 0; m_busy_prev = 0;
        e_wr_req = 0; e_done = 0; e_wr_data = 0;
    endtask

    task automatic enter_armed();
        md = S_ARMED; hist.delete(); armed_cyc = 0;
    endtask

    task automatic model_step();
        int  cur, lvl, flen;
        bit  fire, trig;
        cur  = int'(bus.i_adc_data);
        lvl  = int'(bus.i_trig_level);
        flen = (bus.i_frame_len == 0) ? 1 : int'(bus.i_frame_len);
        e_wr_req = 0; e_done = 0;
        if (bus.i_host_busy && !m_busy_prev) m_ready = 0;
        m_busy_prev = bus.i_host_busy;
        if (bus.i_arm) m_ovr = 0;
        if (bus.i_stop) begin
            md = S_IDLE; hist.delete();
        end else if (md == S_IDLE) begin
            if (bus.i_arm) enter_armed();
        end else if (md == S_ARMED) begin
            fire = bus.i_force;
`ifdef CAPTURE_AUTOTRIG_EN
            if (armed_cyc == TMO - 1) fire = 1;
`endif
            armed_cyc++;
            trig = 0;
            if (bus.i_adc_valid) begin
                if (hist.size() > 0) trig = crossed(hist[$], cur, lvl, bus.i_trig_slope);
                hist.push_back(cur);
                if (hist.size() > 4) void'(hist.pop_front());
            end
            if (trig) begin
                e_wr_req = 1; e_wr_data = cur; left = flen - 1;
                md = (left == 0) ? S_DONE : S_CAP;
            end else if (fire) begin
                left = flen; md = S_CAP;
            end
        end else if (md == S_CAP) begin
            if (bus.i_adc_valid) begin
                e_wr_req = 1; e_wr_data = cur; left--;
                if (left == 0) md = S_DONE;
            end
        end else begin
            if (bus.i_adc_valid && bus.i_cont && !bus.i_arm) m_ovr = 1;
            if (!bus.i_host_busy) begin
                m_buf = ~m_buf; e_done = 1; m_ready = 1;
                if (bus.i_cont) enter_armed(); else md = S_IDLE;
            end
        end
    endtask

    task automatic obs_clear();
        n_wr_seen = 0; n_done_seen = 0; first_wr = -1;
    endtask

    // One clock: predict, advance, compare every output.
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        chk("state", bus.o_state, md);
        chk("buf_sel", bus.o_buf_sel, m_buf);
        chk("wr_req", bus.o_wr_req, e_wr_req);
        if (e_wr_req) chk("wr_data", bus.o_wr_data, e_wr_data);
        chk("frame_done", bus.o_frame_done, e_done);
        chk("frame_ready", bus.o_frame_ready, m_ready);
        chk("overrun", bus.o_overrun, m_ovr);
        if (bus.o_wr_req) begin
            if (n_wr_seen == 0) first_wr = int'(bus.o_wr_data);
            n_wr_seen++;
        end
        if (bus.o_frame_done) n_done_seen++;
    endtask

    task automatic pulse_arm();
        bus.i_arm = 1; tick(); bus.i_arm = 0;
    endtask

    task automatic sample(input int v);
        bus.i_adc_valid = 1; bus.i_adc_data = 12'(v); tick(); bus.i_adc_valid = 0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_state"}, bus.o_state, 0);
        chk({tag, "_buf_sel"}, bus.o_buf_sel, 0);
        chk({tag, "_wr_req"}, bus.o_wr_req, 0);
        chk({tag, "_wr_data"}, bus.o_wr_data, 0);
        chk({tag, "_frame_done"}, bus.o_frame_done, 0);
        chk({tag, "_frame_ready"}, bus.o_frame_ready, 0);
        chk({tag, "_overrun"}, bus.o_overrun, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, summary not reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1;
        bus.i_adc_data = '0; bus.i_adc_valid = 0; bus.i_arm = 0; bus.i_stop = 0;
        bus.i_force = 0; bus.i_cont = 0; bus.i_trig_level = '0; bus.i_trig_slope = 0;
        bus.i_frame_len = '0; bus.i_host_busy = 0;
        #2 reset_n = 0;
        #1 chk_reset_vals("por");
        repeat (2) @(posedge clk);
        #1 reset_n = 1;
        model_reset();

        // Rising trigger on a ramp crossing the MSB boundary.
        obs_clear();
        bus.i_trig_level = 12'd2048; bus.i_trig_slope = 0; bus.i_frame_len = 10'd8; bus.i_cont = 0;
        pulse_arm();
        for (int v = 2040; v <= 2060; v++) sample(v);
        repeat (2) tick();
        chk("rise_first", first_wr, 2048);
        chk("rise_nwr", n_wr_seen, 8);
        chk("rise_ndone", n_done_seen, 1);
        chk("rise_buf", bus.o_buf_sel, 1);

        // Falling trigger, single shot.
        obs_clear();
        bus.i_trig_level = 12'd2500; bus.i_trig_slope = 1; bus.i_frame_len = 10'd4;
        pulse_arm();
        sample(3000);
        sample(2000);
        for (int i = 0; i < 3; i++) sample(int'($urandom_range(0, 4095)));
        tick();
        chk("fall_first", first_wr, 2000);
        chk("fall_nwr", n_wr_seen, 4);
        chk("fall_ndone", n_done_seen, 1);
        chk("fall_idle", bus.o_state, S_IDLE);

        // Swap deferred by host read, continuous mode.
        obs_clear();
        bus.i_trig_level = 12'd100; bus.i_trig_slope = 0; bus.i_cont = 1;
        pulse_arm();
        sample(50);
        sample(150);
        bus.i_host_busy = 1;
        for (int i = 0; i < 3; i++) sample(int'($urandom_range(0, 4095)));
        for (int i = 0; i < 50; i++) begin
            bus.i_adc_valid = (i == 0) ? 1'b1 : ($urandom_range(0, 1) == 1);
            bus.i_adc_data  = 12'($urandom_range(0, 4095));
            tick();
            chk("defer_state", bus.o_state, S_DONE);
            chk("defer_nodone", bus.o_frame_done, 0);
        end
        bus.i_adc_valid = 0;
        chk("defer_ovr", bus.o_overrun, 1);
        bus.i_host_busy = 0;
        tick();
        chk("defer_done", bus.o_frame_done, 1);
        chk("defer_rearm", bus.o_state, S_ARMED);
        pulse_arm();
        chk("arm_clr_ovr", bus.o_overrun, 0);

        // Stop after 3 of 8 samples of a forced frame.
        obs_clear();
        bus.i_cont = 0; bus.i_frame_len = 10'd8;
        bus.i_force = 1; tick(); bus.i_force = 0;
        for (int i = 0; i < 3; i++) sample(int'($urandom_range(0, 4095)));
        bus.i_stop = 1; tick(); bus.i_stop = 0;
        chk("stop_idle", bus.o_state, S_IDLE);
        chk("stop_buf", bus.o_buf_sel, 1);
        repeat (3) tick();
        chk("stop_nwr", n_wr_seen, 3);
        chk("stop_ndone", n_done_seen, 0);

        // Zero frame length with force.
        obs_clear();
        bus.i_frame_len = 10'd0;
        pulse_arm();
        bus.i_force = 1; tick(); bus.i_force = 0;
        sample(int'($urandom_range(0, 4095)));
        tick();
        chk("len0_nwr", n_wr_seen, 1);
        chk("len0_ndone", n_done_seen, 1);
        chk("len0_buf", bus.o_buf_sel, 0);

        // Full-scale boundaries: rising into 4095, falling into 0.
        obs_clear();
        bus.i_frame_len = 10'd2; bus.i_trig_level = 12'd4095; bus.i_trig_slope = 0;
        pulse_arm();
        sample(4094); sample(4095); sample(7); tick();
        chk("top_first", first_wr, 4095);
        obs_clear();
        bus.i_trig_level = 12'd0; bus.i_trig_slope = 1;
        pulse_arm();
        sample(1); sample(0); sample(9); tick();
        chk("bot_first", first_wr, 0);

        // Asynchronous reset in the middle of a frame.
        bus.i_frame_len = 10'd8;
        pulse_arm();
        bus.i_force = 1; tick(); bus.i_force = 0;
        sample(11);
        bus.i_adc_valid = 1; bus.i_adc_data = 12'd22; tick();
        #2 reset_n = 0;
        #1 chk_reset_vals("arst");
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 reset_n = 1;
        model_reset();
        obs_clear();
        for (int i = 0; i < 5; i++) sample(int'($urandom_range(0, 4095)));
        chk("arst_nowr", n_wr_seen, 0);

        // Randomized soak.
        for (int c = 0; c < 1500; c++) begin
            bus.i_arm   = ($urandom_range(0, 11) == 0);
            bus.i_stop  = ($urandom_range(0, 59) == 0);
            bus.i_force = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 9) == 0) bus.i_host_busy = ~bus.i_host_busy;
            if ($urandom_range(0, 19) == 0) bus.i_cont = ~bus.i_cont;
            if (md == S_IDLE) begin
                bus.i_frame_len  = 10'($urandom_range(0, 5));
                bus.i_trig_level = 12'($urandom_range(0, 15));
                bus.i_trig_slope = ($urandom_range(0, 1) == 1);
            end
            bus.i_adc_valid = ($urandom_range(0, 9) < 6);
            bus.i_adc_data  = 12'($urandom_range(0, 15));
            tick();
        end
        bus.i_arm = 0; bus.i_stop = 0; bus.i_force = 0; bus.i_adc_valid = 0;

`ifdef CAPTURE_AUTOTRIG_EN
        // Flat input: the timeout fires on the 16th ARMED cycle.
        bus.i_stop = 1; tick(); bus.i_stop = 0;
        bus.i_host_busy = 0; bus.i_trig_level = 12'd2048; bus.i_trig_slope = 0;
        pulse_arm();
        for (int k = 1; k <= TMO; k++) begin
            bus.i_adc_valid = 1; bus.i_adc_data = 12'd5;
            tick();
            chk("auto_state", bus.o_state, (k < TMO) ? S_ARMED : S_CAP);
        end
        bus.i_adc_valid = 0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/capture_seq_ctrl.md
# capture_seq_ctrl

Trigger and frame sequencer for the ping/pang capture buffers. It watches the ADC sample stream for a level/slope trigger, then writes exactly one frame of samples into the active buffer. It swaps buffers only when the SPI host is not mid-read, and flags each completed frame to the host. It sits between the ADC front end and the ping-pong FIFO pair, and replaces free-running write enables with frame-accurate ones.

## Interface
Parameters:
- DATA_W, 12, sample width
- LEN_W, 10, frame-length counter width
- AUTO_TMO, 100000, auto-trigger timeout in clk cycles (used only with CAPTURE_AUTOTRIG_EN)

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- adc_data  in  DATA_W  sample, qualified by adc_valid
- adc_valid  in  1  one-cycle sample strobe
- arm  in  1  one-cycle pulse: start capture sequence, clear overrun
- stop  in  1  one-cycle pulse: return to IDLE
- force  in  1  one-cycle pulse: immediate trigger when ARMED
- cont  in  1  1 = re-arm automatically after each frame
- trig_level  in  DATA_W  unsigned trigger threshold
- trig_slope  in  1  0 = rising, 1 = falling
- frame_len  in  LEN_W  samples per frame; 0 is treated as 1
- host_busy  in  1  host read in progress (synchronised cs_n low)
- wr_data  out  DATA_W  sample to buffer
- wr_req  out  1  write strobe to the selected buffer
- buf_sel  out  1  buffer being written: 0 = ping, 1 = pang; the host reads the other one
- frame_done  out  1  one-cycle pulse on each buffer swap
- frame_ready  out  1  unread frame available in the read buffer; cleared on host_busy rising edge
- overrun  out  1  sticky: sample dropped in DONE while cont=1
- state  out  2  current state

## Operation
- States: IDLE=00, ARMED=01, CAPTURE=10, DONE=11.
- IDLE: arm -> ARMED. All other inputs are ignored. The trigger-history valid flag is cleared.
- ARMED trigger condition, evaluated on adc_valid:
  - Rising: prev < trig_level and cur >= trig_level.
  - Falling: prev > trig_level and cur <= trig_level.
  - prev is the previous valid sample. No trigger is possible on the first sample after entering ARMED.
- ARMED -> CAPTURE:
  - On trigger: the triggering sample is written as sample 0.
  - On force: the next adc_valid sample is sample 0.
- CAPTURE: every adc_valid produces one wr_req. The counter runs from 0 to frame_len-1. Writing the last sample -> DONE.
- DONE:
  - When host_busy=0, in the same cycle: toggle buf_sel, pulse frame_done, set frame_ready, then go to ARMED if cont=1, else IDLE.
  - While waiting, samples are dropped. If cont=1, any dropped adc_valid sets overrun.
- stop from any state -> IDLE next cycle. A partial frame is abandoned, buf_sel is unchanged, and no frame_done is issued.
- Simultaneous events:
  - stop beats arm, force and swap.
  - arm while not in IDLE is ignored, except that it clears overrun.
  - trigger and force in the same cycle count as one trigger.
- Comparisons are unsigned and full DATA_W width. The counter is LEN_W bits and does not wrap, since the exit happens at frame_len-1.

## Timing
- wr_req and wr_data are registered and appear 1 cycle after the qualifying adc_valid.
- The trigger decision and state change take effect on the same edge that registers sample 0.
- frame_done, the buf_sel toggle and the frame_ready set occur together on one edge, 1 cycle after the DONE entry at the earliest.
- Reset values:
  - state=IDLE, buf_sel=0, wr_req=0, wr_data=0
  - frame_done=0, frame_ready=0, overrun=0
  - counter=0, prev-valid flag=0
- Reset mid-frame discards everything. No write strobe is issued during or after reset until a new arm.

## Configuration
- CAPTURE_AUTOTRIG_EN defined: in ARMED, a cycle counter is reset on entry. When it reaches AUTO_TMO-1 without a trigger, the block behaves as if force were pulsed.
- CAPTURE_AUTOTRIG_EN undefined: no timeout counter; ARMED waits indefinitely for a trigger or force.

## Test plan
- Rising trigger:
  - Stimulus: level=2048, slope=0, frame_len=8, ramp 2040..2060 step 1.
  - Required: first wr_data=2048, exactly 8 wr_req, frame_done once, buf_sel 0->1.
- Falling trigger with cont=0:
  - Stimulus: samples 3000, 2000, level 2500.
  - Required: triggers on 2000, and state returns to IDLE after the swap.
- Swap deferral:
  - Stimulus: host_busy=1 at frame end, held 50 cycles, cont=1.
  - Required: state stays DONE, no frame_done and overrun=1 while busy; frame_done one cycle after release.
- Stop mid-frame:
  - Stimulus: stop after 3 of 8 samples.
  - Required: IDLE next cycle, buf_sel unchanged, no frame_done.
- frame_len=0 and force:
  - Stimulus: force pulse in ARMED.
  - Required: exactly 1 write, then swap.
- Async reset during CAPTURE:
  - Required: all outputs at reset values immediately. With CAPTURE_AUTOTRIG_EN and AUTO_TMO=16, flat input auto-triggers on the 16th ARMED cycle.
